// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared types, constants and helpers for the 4x4 keypad scanner
package keypad_pkg;

    localparam int KEY_W = 4;
    localparam int ROWS  = 4;
    localparam int COLS  = 4;

    localparam logic [COLS-1:0] COL0 = 4'b1110;
    localparam logic [COLS-1:0] COL1 = 4'b1101;
    localparam logic [COLS-1:0] COL2 = 4'b1011;
    localparam logic [COLS-1:0] COL3 = 4'b0111;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
    } state_t;

    function automatic logic [COLS-1:0] col_rotate(input logic [COLS-1:0] col);
        return {col[COLS-2:0], col[COLS-1]};
    endfunction

    function automatic logic [1:0] col_index(input logic [COLS-1:0] col);
        logic [1:0] idx;
        case (col)
            COL1:    idx = 2'd1;
            COL2:    idx = 2'd2;
            COL3:    idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    // Lowest-numbered low row; only meaningful when exactly one row is low.
    function automatic logic [1:0] row_index(input logic [ROWS-1:0] rows);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = ROWS - 1; i >= 0; i--) begin
            if (!rows[i]) idx = 2'(i);
        end
        return idx;
    endfunction

    function automatic logic [2:0] low_count(input logic [ROWS-1:0] rows);
        logic [2:0] cnt;
        cnt = 3'd0;
        for (int i = 0; i < ROWS; i++) begin
            cnt = cnt + 3'(~rows[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/keypad_matrix_scanner_sync2.sv
// rtl/keypad_matrix_scanner_sync2.sv - two-flop synchroniser, resets to all ones (keys released)
module sync2 #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta <= '1;
            q    <= '1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_matrix_scanner.sv
// rtl/keypad_matrix_scanner.sv - 4x4 keypad column scan, row sense, debounce and key-code delivery
module keypad_matrix_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CNT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [ROWS-1:0]  row_in,
    output logic [COLS-1:0]  col_out,
    output logic [KEY_W-1:0] key_code,
    output logic             key_valid,
    output logic             key_held
);

    localparam int DIV_W = $clog2(SCAN_DIV) + 1;
    localparam int DEB_W = $clog2(DEBOUNCE_CNT) + 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [DEB_W-1:0] DEB_TOP  = DEB_W'(DEBOUNCE_CNT);

    logic [ROWS-1:0]  row_s;
    logic [DIV_W-1:0] div_cnt;
    logic [DEB_W-1:0] deb;
    logic [DEB_W-1:0] deb_next;
    logic [KEY_W-1:0] cand;
    logic [KEY_W-1:0] hit_code;
    logic             sample;
    logic             hit;
    state_t           state;

    sync2 #(.W(ROWS)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (row_in),
        .q   (row_s)
    );

    assign sample   = (div_cnt == DIV_LAST);
    // Ghosts (two or more low rows) fall out as "not hit", i.e. idle.
    assign hit      = (low_count(row_s) == 3'd1);
    assign hit_code = {row_index(row_s), col_index(col_out)};
    assign deb_next = deb + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt <= '0;
        end else if (sample) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= SCAN;
            col_out   <= COL0;
            key_code  <= '0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
            deb       <= '0;
            cand      <= '0;
        end else begin
            key_valid <= 1'b0;
            if (sample) begin
                unique case (state)
                    SCAN: begin
                        if (hit) begin
                            cand <= hit_code;
                            if (DEBOUNCE_CNT == 1) begin
                                key_code  <= hit_code;
                                key_valid <= 1'b1;
                                key_held  <= 1'b1;
                                deb       <= '0;
                                state     <= HELD;
                            end else begin
                                deb   <= DEB_W'(1);
                                state <= DEBOUNCE;
                            end
                        end else begin
                            col_out <= col_rotate(col_out);
                        end
                    end
                    DEBOUNCE: begin
                        if (hit && hit_code == cand) begin
                            if (deb_next == DEB_TOP) begin
                                key_code  <= cand;
                                key_valid <= 1'b1;
                                key_held  <= 1'b1;
                                deb       <= '0;
                                state     <= HELD;
                            end else begin
                                deb <= deb_next;
                            end
                        end else begin
                            deb     <= '0;
                            col_out <= col_rotate(col_out);
                            state   <= SCAN;
                        end
                    end
                    HELD: begin
                        // Anything other than the held key counts toward release.
                        if (hit && hit_code == cand) begin
                            deb <= '0;
                        end else if (deb_next == DEB_TOP) begin
                            key_held <= 1'b0;
                            deb      <= '0;
                            col_out  <= col_rotate(col_out);
                            state    <= SCAN;
                        end else begin
                            deb <= deb_next;
                        end
                    end
                    default: begin
                        deb   <= '0;
                        state <= SCAN;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// tb/tb_keypad_matrix_scanner.sv - table-driven bench for keypad_matrix_scanner (SCAN_DIV=4, DEBOUNCE_CNT=3)
module tb_keypad_matrix_scanner;

    localparam int SCAN_DIV = 4;
    localparam int DEB      = 3;

    localparam logic [15:0] NONE = 16'h0000;
    localparam logic [15:0] K9   = 16'h0200;
    localparam logic [15:0] K13  = 16'h2000;
    localparam logic [15:0] K4   = 16'h0010;
    localparam logic [15:0] GH   = 16'h1001;

    typedef struct {
        logic [15:0] mask;
        int          reps;
        logic [3:0]  col;
        logic [3:0]  code;
        logic        held;
        int          valid;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  row_in;
    logic [3:0]  col_out;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
    logic [15:0] pressed = '0;

    int   n_cmp = 0;
    int   n_bad = 0;
    vec_t vecs[$];

    keypad_matrix_scanner #(
        .SCAN_DIV     (SCAN_DIV),
        .DEBOUNCE_CNT (DEB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .row_in    (row_in),
        .col_out   (col_out),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    always #5 clk = ~clk;

    // Keypad model: a pressed key pulls its row low while its column is driven.
    always_comb begin
        row_in = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
            end
        end
    end

    task automatic check(input string name, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic add(input logic [15:0] mask, input int reps, input logic [3:0] col,
                       input logic [3:0] code, input logic held, input int valid);
        vec_t v;
        v.mask = mask; v.reps = reps; v.col = col; v.code = code; v.held = held; v.valid = valid;
        vecs.push_back(v);
    endtask

    // Called on the negedge right after a sample edge; runs exactly one scan period.
    task automatic apply(input vec_t v, input int id);
        int vcnt;
        for (int r = 0; r < v.reps; r++) begin
            pressed = v.mask;
            vcnt = 0;
            for (int i = 0; i < SCAN_DIV; i++) begin
                @(negedge clk);
                if (key_valid === 1'b1) vcnt++;
                check($sformatf("col_onehot v%0d", id), $countones(~col_out), 1);
            end
            check($sformatf("col_out v%0d.%0d", id, r), int'(col_out), int'(v.col));
            check($sformatf("key_code v%0d.%0d", id, r), int'(key_code), int'(v.code));
            check($sformatf("key_held v%0d.%0d", id, r), int'(key_held), int'(v.held));
            check($sformatf("key_valid_cnt v%0d.%0d", id, r), vcnt, v.valid);
        end
    endtask

    initial begin
        // Idle scanning after reset
        add(NONE, 1, 4'b1101, 4'd0, 1'b0, 0);
        add(NONE, 1, 4'b1011, 4'd0, 1'b0, 0);
        add(NONE, 1, 4'b0111, 4'd0, 1'b0, 0);
        add(NONE, 1, 4'b1110, 4'd0, 1'b0, 0);
        // Key 9 (row2/col1) pressed and held
        add(K9,   1, 4'b1101, 4'd0, 1'b0, 0);
        add(K9,   2, 4'b1101, 4'd0, 1'b0, 0);
        add(K9,   1, 4'b1101, 4'd9, 1'b1, 1);
        add(K9,  17, 4'b1101, 4'd9, 1'b1, 0);
        // One-sample release glitch, then real release
        add(NONE, 1, 4'b1101, 4'd9, 1'b1, 0);
        add(K9,   1, 4'b1101, 4'd9, 1'b1, 0);
        add(NONE, 2, 4'b1101, 4'd9, 1'b1, 0);
        add(NONE, 1, 4'b1011, 4'd9, 1'b0, 0);
        add(NONE, 1, 4'b0111, 4'd9, 1'b0, 0);
        add(NONE, 1, 4'b1110, 4'd9, 1'b0, 0);
        add(NONE, 1, 4'b1101, 4'd9, 1'b0, 0);
        // Bounce on key 13 (row3/col1): two samples low then high
        add(K13,  2, 4'b1101, 4'd9, 1'b0, 0);
        add(NONE, 1, 4'b1011, 4'd9, 1'b0, 0);
        add(NONE, 1, 4'b0111, 4'd9, 1'b0, 0);
        add(NONE, 1, 4'b1110, 4'd9, 1'b0, 0);
        // Ghost: rows 0 and 3 low in col0
        add(GH,   1, 4'b1101, 4'd9, 1'b0, 0);
        add(GH,   1, 4'b1011, 4'd9, 1'b0, 0);
        add(GH,   1, 4'b0111, 4'd9, 1'b0, 0);
        add(GH,   1, 4'b1110, 4'd9, 1'b0, 0);
        add(GH,   1, 4'b1101, 4'd9, 1'b0, 0);
        // Key 4 (row1/col0) reaches HELD for the reset test
        add(K4,   1, 4'b1011, 4'd9, 1'b0, 0);
        add(K4,   1, 4'b0111, 4'd9, 1'b0, 0);
        add(K4,   1, 4'b1110, 4'd9, 1'b0, 0);
        add(K4,   2, 4'b1110, 4'd9, 1'b0, 0);
        add(K4,   1, 4'b1110, 4'd4, 1'b1, 1);
        add(K4,   2, 4'b1110, 4'd4, 1'b1, 0);

        #1 rst = 1'b0;
        #1;
        check("reset col_out", int'(col_out), 4'b1110);
        check("reset key_code", int'(key_code), 0);
        check("reset key_valid", int'(key_valid), 0);
        check("reset key_held", int'(key_held), 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        foreach (vecs[i]) apply(vecs[i], i);

        // Asynchronous reset while HELD on key 4
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("midrst key_held", int'(key_held), 0);
        check("midrst key_code", int'(key_code), 0);
        check("midrst key_valid", int'(key_valid), 0);
        check("midrst col_out", int'(col_out), 4'b1110);
        repeat (2) begin
            @(negedge clk);
            check("inrst key_valid", int'(key_valid), 0);
        end
        rst = 1'b1;

        begin
            vec_t v;
            v.mask = K4; v.reps = 2; v.col = 4'b1110; v.code = 4'd0; v.held = 1'b0; v.valid = 0;
            apply(v, 100);
            v.reps = 1; v.code = 4'd4; v.held = 1'b1; v.valid = 1;
            apply(v, 101);
            v.mask = NONE; v.reps = 2; v.valid = 0;
            apply(v, 102);
            v.reps = 1; v.col = 4'b1101; v.held = 1'b0;
            apply(v, 103);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
